// File: rtl/wb_pkg.sv
// Shared defaults and the queue entry layout for the register-file writeback path.
// Latency: n/a (types only). Backpressure: n/a.
package wb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [AW_DEF-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order entry storage with per-slot valid bits exposed for associative search.
// Latency: a push is visible on the entry outputs the cycle after the edge. Backpressure: push ignored when full, pop ignored when empty.
module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_dat,
    input  logic          pop,
    output entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] vld,
    output logic [PW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload is left uncleared on reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Arbitrates ALU/load writebacks into an in-order queue that drives the register file write port; optional WB_BYPASS_EN adds forwarding data.
// Latency: accepted request is written the cycle after acceptance (into an empty queue); one write drains per cycle.
// Backpressure: port A has fixed priority, B only when A idle; nothing accepted while full or in reset.
module reg_writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic [AW-1:0]          a_rd,
    input  logic [XLEN-1:0]        a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [AW-1:0]          b_rd,
    input  logic [XLEN-1:0]        b_data,
    output logic                   b_ready,
    output logic [AW-1:0]          rd,
    output logic [XLEN-1:0]        rd_din,
    output logic                   write_enable,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [XLEN-1:0]        rs1_fwd_data,
    output logic [XLEN-1:0]        rs2_fwd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t           entries [DEPTH];
    entry_t           push_dat;
    entry_t           head_ent;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head_ptr;
    logic             full;
    logic             empty;
    logic             a_fire;
    logic             b_fire;
    logic             push;

    assign a_ready = !reset && !full;
    assign b_ready = !reset && !full && !a_valid;
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    always_comb begin
        push_dat      = '0;
        push_dat.rd   = a_fire ? a_rd : b_rd;
        push_dat.data = a_fire ? a_data : b_data;
    end

    // x0 writes finish the handshake but never occupy a slot.
    assign push = (a_fire || b_fire) && (push_dat.rd != '0);

    wb_entry_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (!empty),
        .entries  (entries),
        .vld      (vld),
        .head     (head_ptr),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign head_ent     = entries[head_ptr];
    assign write_enable = !empty;
    assign rd           = empty ? '0 : head_ent.rd;
    assign rd_din       = empty ? '0 : head_ent.data;

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (entries[i].rd == rs1) && (rs1 != '0)) rs1_busy = 1'b1;
            if (vld[i] && (entries[i].rd == rs2) && (rs2 != '0)) rs2_busy = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match (the youngest) wins; valid slots are contiguous from head.
    always_comb begin
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (vld[idx] && (entries[idx].rd == rs1) && (rs1 != '0)) rs1_fwd_data = entries[idx].data;
            if (vld[idx] && (entries[idx].rd == rs2) && (rs2 != '0)) rs2_fwd_data = entries[idx].data;
        end
    end
`else
    assign rs1_fwd_data = '0;
    assign rs2_fwd_data = '0;
`endif

endmodule
